// File: rtl/gray_seq_gen_if.sv
// Handshake/bus bundle for gray_seq_gen: control inputs plus code/status outputs.
// The pause signal exists only when GRAY_SEQ_PAUSE_EN is defined.
interface gray_seq_gen_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic             stop;
    logic             mode;
    logic             dir;
`ifdef GRAY_SEQ_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] code;
    logic [WIDTH-1:0] bin;
    logic             step;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode, dir,
`ifdef GRAY_SEQ_PAUSE_EN
        output pause,
`endif
        input  code, bin, step, busy, done
    );

    modport slave (
        input  start, stop, mode, dir,
`ifdef GRAY_SEQ_PAUSE_EN
        input  pause,
`endif
        output code, bin, step, busy, done
    );
endinterface

// File: rtl/gray_seq_gen.sv
// Gray-code sequence generator: walks all 2^WIDTH codes, each held DWELL cycles,
// single-pass or free-run, up or down. GRAY_SEQ_PAUSE_EN adds a pause input.
module gray_seq_gen #(
    parameter int WIDTH = 3,
    parameter int DWELL = 50
) (
    input  logic          clk,
    input  logic          rst,
    gray_seq_gen_if.slave bus
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_bin, w_bin_nxt;
    logic [WIDTH-1:0] r_code;
    logic             r_mode, w_mode_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_step, w_step_nxt;
    logic             r_busy, r_done;
    logic             w_pause;

`ifdef GRAY_SEQ_PAUSE_EN
    assign w_pause = bus.pause;
`else
    assign w_pause = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_code  <= '0;
            r_mode  <= 1'b0;
            r_dir   <= 1'b0;
            r_step  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bin   <= w_bin_nxt;
            // Outputs are derived from next-state values so they stay registered.
            r_code  <= w_bin_nxt ^ (w_bin_nxt >> 1);
            r_mode  <= w_mode_nxt;
            r_dir   <= w_dir_nxt;
            r_step  <= w_step_nxt;
            r_busy  <= (w_state_nxt == RUN);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bin_nxt   = r_bin;
        w_mode_nxt  = r_mode;
        w_dir_nxt   = r_dir;
        w_step_nxt  = 1'b0;
        if (bus.stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_bin_nxt   = '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        w_state_nxt = RUN;
                        w_cnt_nxt   = '0;
                        w_bin_nxt   = '0;
                        w_mode_nxt  = bus.mode;
                        w_dir_nxt   = bus.dir;
                    end
                end
                RUN: begin
                    if (!w_pause) begin
                        if (r_cnt == LAST) begin
                            w_cnt_nxt  = '0;
                            w_bin_nxt  = r_dir ? (r_bin - WIDTH'(1)) : (r_bin + WIDTH'(1));
                            w_step_nxt = 1'b1;
                            // Single pass ends on the advance that lands back on index 0.
                            if (!r_mode && (w_bin_nxt == '0))
                                w_state_nxt = DONE;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign bus.code = r_code;
    assign bus.bin  = r_bin;
    assign bus.step = r_step;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule
